hazard_stall_controller: RTL
============================

# hazard_stall_controller

Pipeline hazard sequencer for the 5-stage core, sitting beside the operand forwarding logic. It covers the hazards that forwarding alone cannot resolve:
- load-use bubbles;
- multi-cycle memory-stage freezes;
- taken-branch squash of the wrong-path fetch;
- interrupt drain/acknowledge sequencing.

It drives the PC write enable and the enable/flush controls of the F2D, D2E, E2M and M2W pipeline registers.

## Interface
Parameters:
- MEM_CYCLES, 2: cycles one memory-stage access occupies; legal range 1..8; 1 = never freezes.
- DRAIN_CYCLES, 3: bubble cycles that empty the D, E and M stages before interrupt acknowledge; legal range 1..7.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- srcAAfterF2D  in  3  first source register of the decode-stage instruction.
- srcBAfterF2D  in  3  second source register of the decode-stage instruction.
- usesSrcA  in  1  decode-stage instruction reads srcA.
- usesSrcB  in  1  decode-stage instruction reads srcB.
- destAfterD2E  in  3  destination register of the execute-stage instruction.
- MTRAfterD2E  in  1  execute-stage instruction loads from memory.
- RWAfterD2E  in  1  execute-stage instruction writes the register file.
- memOpAfterE2M  in  1  memory-stage instruction performs a memory access.
- branchTakenD  in  1  branch resolved taken in decode.
- intReq  in  1  level interrupt request.
- pcWrite  out  1  PC update enable.
- F2DEnable  out  1  F2D register load enable.
- D2EEnable  out  1  D2E register load enable.
- E2MEnable  out  1  E2M register load enable.
- F2DFlush  out  1  F2D register loads a NOP.
- D2EFlush  out  1  D2E register loads a NOP.
- M2WFlush  out  1  M2W register loads a NOP.
- intAck  out  1  one-cycle interrupt acknowledge.

## Operation
States: RUN, MEM_WAIT, INT_DRAIN. Registered state: memCnt (3 bits), drainCnt (3 bits), intPending.

Defaults (no hazard, RUN):
- pcWrite, F2DEnable, D2EEnable, E2MEnable = 1.
- All flushes = 0; intAck = 0.

**Load-use hazard.** loadUse = MTRAfterD2E & RWAfterD2E & ((usesSrcA & srcAAfterF2D==destAfterD2E) | (usesSrcB & srcBAfterF2D==destAfterD2E)).
- Response in RUN: pcWrite=0, F2DEnable=0, D2EFlush=1.
- Lasts exactly one cycle per occurrence; no state change.

**Multi-cycle memory.**
- In RUN, memOpAfterE2M=1 with MEM_CYCLES>1 enters MEM_WAIT and sets memCnt=MEM_CYCLES-1.
- In MEM_WAIT: pcWrite, F2DEnable, D2EEnable, E2MEnable = 0; M2WFlush=1; memCnt decrements each cycle.
- memCnt reaching 1 returns to RUN on the next edge, so the freeze lasts MEM_CYCLES-1 cycles.

**Branch.** In RUN with no load-use and not entering MEM_WAIT, branchTakenD gives F2DFlush=1 for one cycle.

**Interrupt.**
- intReq sampled high in any state sets intPending.
- In RUN, with intPending set and no load-use, memory op or branch, the block enters INT_DRAIN with drainCnt=DRAIN_CYCLES.
- In INT_DRAIN: pcWrite=0, F2DFlush=1, D2EFlush=1; drainCnt decrements each cycle.
- When drainCnt reaches 0: intAck=1 for one cycle, intPending is cleared, and the block returns to RUN.

**Priority, highest first:** rst > MEM_WAIT / memory-freeze entry > load-use > branch > interrupt entry.
- A branchTakenD coinciding with a load-use is ignored; decode re-presents it next cycle.
- A memOpAfterE2M arriving during INT_DRAIN takes priority:
  - freeze outputs apply;
  - drainCnt holds;
  - the state returns to INT_DRAIN, not RUN, after the freeze.

## Timing
- Outputs are combinational from current state and inputs (Mealy). State and counters update on the rising clk edge.
- Reset (asynchronous):
  - registered state: state=RUN, memCnt=0, drainCnt=0, intPending=0;
  - while rst=1: pcWrite=0, F2DEnable=1, D2EEnable=1, E2MEnable=1, F2DFlush=1, D2EFlush=1, M2WFlush=1, intAck=0.
- Reset asserted mid-MEM_WAIT or mid-INT_DRAIN aborts the sequence. A pending interrupt is lost.
- Latencies:
  - load-use bubble: 0 cycles (same-cycle response);
  - interrupt: intAck occurs DRAIN_CYCLES+1 cycles after the entry edge, absent freezes.
- intReq held high after intAck re-sets intPending, so a held request is serviced again.

## Configuration
- Macro: HAZARD_INT_CTRL_EN.
- Defined: interrupt sequencing (intPending, INT_DRAIN, intAck) is present as specified above.
- Undefined:
  - intReq is ignored;
  - intAck is tied to 0;
  - INT_DRAIN and drainCnt are not implemented;
  - all other behaviour is identical.

## Test plan
- Load-use: MTRAfterD2E=1, RWAfterD2E=1, destAfterD2E=3, srcAAfterF2D=3, usesSrcA=1 → the same cycle gives pcWrite=0, F2DEnable=0, D2EFlush=1; the next cycle, with E-stage inputs cleared, outputs are back to defaults.
- Same registers but usesSrcA=0, or RWAfterD2E=0 → no stall.
- MEM_CYCLES=3, memOpAfterE2M pulsed one cycle in RUN → exactly 2 freeze cycles (E2MEnable=0, M2WFlush=1), then RUN.
- MEM_CYCLES=1 → never freezes.
- branchTakenD=1 together with a load-use → only the load-use response, F2DFlush=0.
- branchTakenD=1 alone → F2DFlush=1 for one cycle.
- With the macro defined, intReq pulsed in RUN (DRAIN_CYCLES=3) → 3 cycles of pcWrite=0, F2DFlush=1, D2EFlush=1, then intAck=1 for one cycle.
- memOpAfterE2M during drain → drain extended by MEM_CYCLES-1 cycles.
- rst asserted asynchronously mid-MEM_WAIT → outputs immediately take reset values; after release, RUN defaults with no residual freeze and intAck=0.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline hazard sequencer for the 5-stage core.
// Handles load-use bubbles, multi-cycle memory freezes, taken-branch squash
// and (optionally) interrupt drain/acknowledge sequencing.
// Optional feature macro: HAZARD_INT_CTRL_EN (interrupt sequencing present
// when defined; intReq ignored and intAck tied low when undefined).
module hazard_stall_controller #(
  parameter int unsigned MEM_CYCLES   = 2,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] srcAAfterF2D,
  input  logic [2:0] srcBAfterF2D,
  input  logic       usesSrcA,
  input  logic       usesSrcB,
  input  logic [2:0] destAfterD2E,
  input  logic       MTRAfterD2E,
  input  logic       RWAfterD2E,
  input  logic       memOpAfterE2M,
  input  logic       branchTakenD,
  input  logic       intReq,
  output logic       pcWrite,
  output logic       F2DEnable,
  output logic       D2EEnable,
  output logic       E2MEnable,
  output logic       F2DFlush,
  output logic       D2EFlush,
  output logic       M2WFlush,
  output logic       intAck
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1
`ifdef HAZARD_INT_CTRL_EN
    ,INT_DRAIN = 2'd2
`endif
  } state_e;

  localparam logic [2:0] MEM_INIT  = 3'(MEM_CYCLES - 1);
  localparam logic       MEM_MULTI = (MEM_CYCLES > 1);

  state_e     state_q, state_d;
  logic [2:0] memCnt_q, memCnt_d;
  logic       loadUse;
  logic       memEntry;

  assign loadUse = MTRAfterD2E & RWAfterD2E &
                   ((usesSrcA & (srcAAfterF2D == destAfterD2E)) |
                    (usesSrcB & (srcBAfterF2D == destAfterD2E)));

  // A memory op only freezes the pipe when an access spans several cycles.
  assign memEntry = memOpAfterE2M & MEM_MULTI;

`ifdef HAZARD_INT_CTRL_EN
  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

  logic [2:0] drainCnt_q, drainCnt_d;
  logic       intPending_q, intPending_d;
  logic       retDrain_q, retDrain_d;

  // Interrupt bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drainCnt_q   <= '0;
      intPending_q <= 1'b0;
      retDrain_q   <= 1'b0;
    end else begin
      drainCnt_q   <= drainCnt_d;
      intPending_q <= intPending_d;
      retDrain_q   <= retDrain_d;
    end
  end
`else
  logic unused_int;
  assign unused_int = ^{intReq, 3'(DRAIN_CYCLES)};
`endif

  // State and memory-freeze counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      memCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      memCnt_q <= memCnt_d;
    end
  end

  // Next-state logic and Mealy outputs, reset overrides applied last.
  always_comb begin
    state_d   = state_q;
    memCnt_d  = memCnt_q;
    pcWrite   = 1'b1;
    F2DEnable = 1'b1;
    D2EEnable = 1'b1;
    E2MEnable = 1'b1;
    F2DFlush  = 1'b0;
    D2EFlush  = 1'b0;
    M2WFlush  = 1'b0;
    intAck    = 1'b0;
`ifdef HAZARD_INT_CTRL_EN
    drainCnt_d   = drainCnt_q;
    retDrain_d   = retDrain_q;
    intPending_d = intPending_q | intReq;
`endif

    case (state_q)
      RUN: begin
        if (memEntry) begin
          state_d  = MEM_WAIT;
          memCnt_d = MEM_INIT;
`ifdef HAZARD_INT_CTRL_EN
          retDrain_d = 1'b0;
`endif
        end else if (loadUse) begin
          pcWrite   = 1'b0;
          F2DEnable = 1'b0;
          D2EFlush  = 1'b1;
        end else if (branchTakenD) begin
          F2DFlush = 1'b1;
        end
`ifdef HAZARD_INT_CTRL_EN
        else if (intPending_q) begin
          state_d    = INT_DRAIN;
          drainCnt_d = DRAIN_INIT;
        end
`endif
      end

      MEM_WAIT: begin
        pcWrite   = 1'b0;
        F2DEnable = 1'b0;
        D2EEnable = 1'b0;
        E2MEnable = 1'b0;
        M2WFlush  = 1'b1;
        if (memCnt_q <= 3'd1) begin
          memCnt_d = '0;
`ifdef HAZARD_INT_CTRL_EN
          state_d  = retDrain_q ? INT_DRAIN : RUN;
`else
          state_d  = RUN;
`endif
        end else begin
          memCnt_d = memCnt_q - 3'd1;
        end
      end

`ifdef HAZARD_INT_CTRL_EN
      // A memory op during the drain detours through MEM_WAIT and comes back
      // here; the counter is frozen while away, and the acknowledge is deferred
      // if the op lands on the acknowledge cycle.
      INT_DRAIN: begin
        if (drainCnt_q != 3'd0 || memEntry) begin
          pcWrite  = 1'b0;
          F2DFlush = 1'b1;
          D2EFlush = 1'b1;
          if (drainCnt_q != 3'd0) drainCnt_d = drainCnt_q - 3'd1;
          if (memEntry) begin
            state_d    = MEM_WAIT;
            memCnt_d   = MEM_INIT;
            retDrain_d = 1'b1;
          end
        end else begin
          intAck       = 1'b1;
          state_d      = RUN;
          retDrain_d   = 1'b0;
          intPending_d = intReq;
        end
      end
`endif

      default: state_d = RUN;
    endcase

    if (rst) begin
      pcWrite   = 1'b0;
      F2DEnable = 1'b1;
      D2EEnable = 1'b1;
      E2MEnable = 1'b1;
      F2DFlush  = 1'b1;
      D2EFlush  = 1'b1;
      M2WFlush  = 1'b1;
      intAck    = 1'b0;
    end
  end

endmodule
